// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the sequential ALU. This package holds
//               the mode codes, the FSM state encoding, the flag bit indices
//               and the signed-overflow helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes presented on the mode input
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_INC = 4'h2;
    localparam logic [3:0] ALU_DEC = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_XOR = 4'h6;
    localparam logic [3:0] ALU_CMP = 4'h7;
    localparam logic [3:0] ALU_ADC = 4'h8;
    localparam logic [3:0] ALU_SBB = 4'h9;
    localparam logic [3:0] ALU_SHL = 4'hA;
    localparam logic [3:0] ALU_SHR = 4'hB;
    localparam logic [3:0] ALU_ROL = 4'hC;
    localparam logic [3:0] ALU_ROR = 4'hD;
    localparam logic [3:0] ALU_MUL = 4'hE;
    localparam logic [3:0] ALU_NOT = 4'hF;

    // Controller states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bit positions inside the registered flag vector
    localparam int FLAG_W        = 4;
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_CARRY    = 1;
    localparam int FLAG_NEGATIVE = 2;
    localparam int FLAG_OVERFLOW = 3;

    // Signed overflow of a + b: operands agree in sign, result disagrees
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of a - b (also valid with a borrow-in)
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative unsigned N x N shift-add multiplier. A start pulse
//               loads the operands, N iterations follow, and then done
//               pulses for one cycle while product holds the result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int            CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    logic [N-1:0]   r_a;
    logic [2*N-1:0] r_acc;     // {partial high word, remaining multiplier bits}
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [N:0]     w_sum;

    // The multiplicand is added into the high half when the current multiplier LSB is set
    assign w_sum = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_a} : {(N+1){1'b0}});

    // Load on start, then do one add-and-shift step per cycle until the last bit is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a    <= a;
                r_acc  <= {{N{1'b0}}, b};
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= {w_sum, r_acc[N-1:1]};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. It runs one operation per accepted
//               request. Single-cycle modes complete on the accept edge.
//               MUL runs through the iterative multiplier. Results and flags
//               are held until the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   mode,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [N-1:0] out_hi,
    output logic         flag_zero,
    output logic         flag_carry,
    output logic         flag_negative,
    output logic         flag_overflow,
    output logic         busy
);

    logic [1:0]        r_state;
    logic [N-1:0]      r_out;
    logic [N-1:0]      r_out_hi;
    logic [FLAG_W-1:0] r_flags;

    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_done;
    logic              w_mul_busy;
    logic [2*N-1:0]    w_product;

    logic [N:0]        w_ext;      // (N+1)-bit arithmetic result, bit N is carry/borrow
    logic [N-1:0]      w_res;
    logic              w_carry;
    logic              w_ovf;
    logic              w_arith;
    logic              w_keep_out; // CMP updates flags only

    assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (mode == ALU_MUL);

    alu_mul_iter #(
        .N (N)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Single-cycle datapath: result, carry and overflow for every non-MUL mode
    always_comb begin
        w_ext      = '0;
        w_res      = '0;
        w_carry    = 1'b0;
        w_ovf      = 1'b0;
        w_arith    = 1'b0;
        w_keep_out = 1'b0;
        case (mode)
            ALU_ADD: begin
                w_arith = 1'b1;
                w_ext   = {1'b0, in_a} + {1'b0, in_b};
                w_ovf   = add_ovf(in_a[N-1], in_b[N-1], w_ext[N-1]);
            end
            ALU_SUB, ALU_CMP: begin
                w_arith    = 1'b1;
                w_keep_out = (mode == ALU_CMP);
                w_ext      = {1'b0, in_a} - {1'b0, in_b};
                w_ovf      = sub_ovf(in_a[N-1], in_b[N-1], w_ext[N-1]);
            end
            ALU_INC: begin
                w_arith = 1'b1;
                w_ext   = {1'b0, in_a} + (N+1)'(1);
                w_ovf   = add_ovf(in_a[N-1], 1'b0, w_ext[N-1]);
            end
            ALU_DEC: begin
                w_arith = 1'b1;
                w_ext   = {1'b0, in_a} - (N+1)'(1);
                w_ovf   = sub_ovf(in_a[N-1], 1'b0, w_ext[N-1]);
            end
            ALU_ADC: begin
                w_arith = 1'b1;
                w_ext   = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, r_flags[FLAG_CARRY]};
                w_ovf   = add_ovf(in_a[N-1], in_b[N-1], w_ext[N-1]);
            end
            ALU_SBB: begin
                w_arith = 1'b1;
                w_ext   = {1'b0, in_a} - {1'b0, in_b} - {{N{1'b0}}, r_flags[FLAG_CARRY]};
                w_ovf   = sub_ovf(in_a[N-1], in_b[N-1], w_ext[N-1]);
            end
            ALU_AND: w_res = in_a & in_b;
            ALU_OR:  w_res = in_a | in_b;
            ALU_XOR: w_res = in_a ^ in_b;
            ALU_NOT: w_res = ~in_a;
            ALU_SHL: begin
                w_res   = {in_a[N-2:0], 1'b0};
                w_carry = in_a[N-1];
            end
            ALU_SHR: begin
                w_res   = {1'b0, in_a[N-1:1]};
                w_carry = in_a[0];
            end
            ALU_ROL: begin
                w_res   = {in_a[N-2:0], in_a[N-1]};
                w_carry = in_a[N-1];
            end
            ALU_ROR: begin
                w_res   = {in_a[0], in_a[N-1:1]};
                w_carry = in_a[0];
            end
            default: ; // MUL is handled by the iterative multiplier
        endcase
        if (w_arith) begin
            w_res   = w_ext[N-1:0];
            w_carry = w_ext[N];
        end
    end

    // Controller and result registers; these are written only when a result completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_out    <= '0;
            r_out_hi <= '0;
            r_flags  <= '0;
        end else if (w_accept && (mode != ALU_MUL)) begin
            r_state <= DONE;
            if (!w_keep_out) begin
                r_out    <= w_res;
                r_out_hi <= '0;
            end
            r_flags[FLAG_ZERO]     <= (w_res == '0);
            r_flags[FLAG_CARRY]    <= w_carry;
            r_flags[FLAG_NEGATIVE] <= w_res[N-1];
            r_flags[FLAG_OVERFLOW] <= w_ovf;
        end else if (w_accept) begin
            r_state <= MUL;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_state                <= DONE;
            r_out                  <= w_product[N-1:0];
            r_out_hi               <= w_product[2*N-1:N];
            r_flags[FLAG_ZERO]     <= (w_product == '0);
            r_flags[FLAG_CARRY]    <= (w_product[2*N-1:N] != '0);
            r_flags[FLAG_NEGATIVE] <= w_product[2*N-1];
            r_flags[FLAG_OVERFLOW] <= 1'b0;
        end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
        end else if (r_state == 2'd3) begin
            r_state <= IDLE;   // unreachable encoding, recover rather than lock up
        end
    end

    assign out_valid     = (r_state == DONE);
    assign out           = r_out;
    assign out_hi        = r_out_hi;
    assign flag_zero     = r_flags[FLAG_ZERO];
    assign flag_carry    = r_flags[FLAG_CARRY];
    assign flag_negative = r_flags[FLAG_NEGATIVE];
    assign flag_overflow = r_flags[FLAG_OVERFLOW];
    assign busy          = w_mul_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq. It uses an 8-bit
//               instance for the functional vectors and a 16-bit instance
//               for the streaming back-pressure scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 8-bit instance
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]  mode = 4'h0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        in_ready, out_valid, busy;
    logic [7:0]  out, out_hi;
    logic        fz, fc, fn, fv;
    wire  [3:0]  flags = {fz, fc, fn, fv};

    // 16-bit instance
    logic        v16 = 1'b0, ordy16 = 1'b0;
    logic [3:0]  m16 = ALU_ADD;
    logic [15:0] a16 = '0, b16 = '0;
    logic        rdy16, ov16, busy16;
    logic [15:0] out16, hi16;
    logic        fz16, fc16, fn16, fv16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_hi(out_hi), .flag_zero(fz), .flag_carry(fc), .flag_negative(fn),
        .flag_overflow(fv), .busy(busy)
    );

    alu_seq #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .mode(m16),
        .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(ordy16), .out(out16),
        .out_hi(hi16), .flag_zero(fz16), .flag_carry(fc16), .flag_negative(fn16),
        .flag_overflow(fv16), .busy(busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to the 8-bit instance for a single accepting edge
    task automatic issue8(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input string name);
        in_valid = 1'b1; mode = m; in_a = a; in_b = b;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Take the held result from the 8-bit instance
    task automatic consume8(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_consumed got=%b exp=0", name, out_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({out, out_hi, flags, out_valid, busy} !== 22'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {out, out_hi, flags, out_valid, busy});
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue8(ALU_ADD, 8'hFF, 8'h01, "add_ff_01");
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency out_valid=%b exp=1", out_valid); end
        checks++;
        if ({out, out_hi, flags} !== {8'h00, 8'h00, 4'b1100}) begin
            failures++; $display("FAIL add_ff_01 got=%h exp=%h", {out, out_hi, flags}, {8'h00, 8'h00, 4'b1100});
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL add_stall_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h00, 4'b1100}) begin
            failures++; $display("FAIL add_hold got=%h exp=%h", {out_valid, out, flags}, {1'b1, 8'h00, 4'b1100});
        end
        consume8("add");
    endtask

    task automatic test_sub_sbb();
        issue8(ALU_SUB, 8'h10, 8'h20, "sub");
        checks++;
        if ({out, flags} !== {8'hF0, 4'b0110}) begin
            failures++; $display("FAIL sub_10_20 got=%h exp=%h", {out, flags}, {8'hF0, 4'b0110});
        end
        consume8("sub");
        issue8(ALU_SBB, 8'h05, 8'h01, "sbb");
        checks++;
        if ({out, flags} !== {8'h03, 4'b0000}) begin
            failures++; $display("FAIL sbb_05_01_c1 got=%h exp=%h", {out, flags}, {8'h03, 4'b0000});
        end
        consume8("sbb");
    endtask

    task automatic test_cmp();
        issue8(ALU_ADD, 8'h90, 8'h09, "cmp_setup");
        checks++;
        if ({out, flags} !== {8'h99, 4'b0010}) begin
            failures++; $display("FAIL cmp_setup got=%h exp=%h", {out, flags}, {8'h99, 4'b0010});
        end
        consume8("cmp_setup");
        issue8(ALU_CMP, 8'h42, 8'h42, "cmp");
        checks++;
        if ({out_valid, out, out_hi, flags} !== {1'b1, 8'h99, 8'h00, 4'b1000}) begin
            failures++; $display("FAIL cmp_42_42 got=%h exp=%h", {out_valid, out, out_hi, flags}, {1'b1, 8'h99, 8'h00, 4'b1000});
        end
        consume8("cmp");
    endtask

    task automatic test_mul();
        int lat;
        int bcnt;
        int seen;
        issue8(ALU_MUL, 8'hFF, 8'hFF, "mul");
        lat = 0; bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", lat); end
        checks++;
        if (bcnt !== 8) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=8", bcnt); end
        checks++;
        if ({out, out_hi, flags, busy} !== {8'h01, 8'hFE, 4'b0110, 1'b0}) begin
            failures++; $display("FAIL mul_ff_ff got=%h exp=%h", {out, out_hi, flags, busy}, {8'h01, 8'hFE, 4'b0110, 1'b0});
        end
        consume8("mul");

        // Second run, aborted by reset partway through
        issue8(ALU_MUL, 8'h0F, 8'h03, "mul_abort");
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mul_abort_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, out_hi, flags, out_valid, busy, in_ready} !== {22'd0, 1'b1}) begin
            failures++; $display("FAIL mul_abort_reset got=%h exp=%h", {out, out_hi, flags, out_valid, busy, in_ready}, {22'd0, 1'b1});
        end
        tick();
        rst_n = 1'b1;
        // Mode wiggling without in_valid must not start anything
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            mode = 4'(i);
            in_a = 8'h5A;
            tick();
            if (out_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL mul_abort_quiet got=%0d exp=0", seen); end
        checks++;
        if ({out, out_hi} !== 16'h0000) begin failures++; $display("FAIL mul_abort_out got=%h exp=0000", {out, out_hi}); end
    endtask

    task automatic test_ovf_shift();
        issue8(ALU_ADD, 8'h7F, 8'h01, "ovf");
        checks++;
        if ({out, flags} !== {8'h80, 4'b0011}) begin
            failures++; $display("FAIL add_7f_01 got=%h exp=%h", {out, flags}, {8'h80, 4'b0011});
        end
        consume8("ovf");
        issue8(ALU_ROR, 8'h01, 8'h00, "ror");
        checks++;
        if ({out, flags} !== {8'h80, 4'b0110}) begin
            failures++; $display("FAIL ror_01 got=%h exp=%h", {out, flags}, {8'h80, 4'b0110});
        end
        consume8("ror");
        issue8(ALU_SHL, 8'h80, 8'h00, "shl");
        checks++;
        if ({out, flags} !== {8'h00, 4'b1100}) begin
            failures++; $display("FAIL shl_80 got=%h exp=%h", {out, flags}, {8'h00, 4'b1100});
        end
        consume8("shl");
    endtask

    task automatic test_back_to_back();
        logic [15:0] va  [6] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h0001, 16'h7FFF, 16'hABCD};
        logic [15:0] vb  [6] = '{16'h0001, 16'h1111, 16'h8000, 16'h0002, 16'h0001, 16'h1234};
        logic [15:0] exp [6] = '{16'h0000, 16'h2345, 16'h0000, 16'h0003, 16'h8000, 16'hBE01};
        logic [35:0] held;
        logic        stalled;
        logic        acc;
        int sent;
        int rcv;
        sent = 0; rcv = 0; held = '0;
        m16 = ALU_ADD;
        for (int cyc = 0; cyc < 80 && rcv < 6; cyc++) begin
            v16 = (sent < 6);
            if (sent < 6) begin a16 = va[sent]; b16 = vb[sent]; end
            ordy16 = ((cyc % 2) == 1);
            #1;
            stalled = 1'b0;
            if (ov16 && !ordy16) begin
                stalled = 1'b1;
                held = {out16, hi16, fz16, fc16, fn16, fv16};
                checks++;
                if (rdy16 !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%b exp=0", cyc, rdy16); end
            end
            if (ov16 && ordy16) begin
                checks++;
                if (out16 !== exp[rcv]) begin failures++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", rcv, out16, exp[rcv]); end
                rcv++;
            end
            acc = v16 && rdy16;
            tick();
            if (acc) sent++;
            if (stalled) begin
                checks++;
                if ({ov16, out16, hi16, fz16, fc16, fn16, fv16} !== {1'b1, held}) begin
                    failures++; $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", cyc, {ov16, out16, hi16, fz16, fc16, fn16, fv16}, {1'b1, held});
                end
            end
        end
        v16 = 1'b0;
        ordy16 = 1'b0;
        checks++;
        if (rcv !== 6 || sent !== 6) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=6/6", sent, rcv); end
        checks++;
        if (ov16 !== 1'b0) begin failures++; $display("FAIL b2b_no_duplicate got=%b exp=0", ov16); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_sbb();
        test_cmp();
        test_mul();
        test_ovf_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
